// File: rtl/button_hit_conditioner_pkg.sv
// Shared constants for the rhythm button conditioner.
// Debounce state encoding and 50 MHz default timing.
package button_hit_conditioner_pkg;

    localparam logic [1:0] ST_REL   = 2'd0;
    localparam logic [1:0] ST_CHK_P = 2'd1;
    localparam logic [1:0] ST_PRS   = 2'd2;
    localparam logic [1:0] ST_CHK_R = 2'd3;

    // 10 ms of stable input at 50 MHz
    localparam int DEBOUNCE_CYCLES_50MHZ = 500000;
    localparam int DEBOUNCE_CNT_W        = 20;

endpackage

// File: rtl/button_hit_conditioner_debounce_fsm.sv
// Synchroniser, stability counter and debounce FSM.
// Emits one press_evt per debounced press.
module button_hit_conditioner_debounce_fsm
    import button_hit_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int CNT_W           = DEBOUNCE_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    output logic o_btn_level,
    output logic o_press_evt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_evt;
    logic             w_s;

    assign w_s = ~r_sync2;

    // Two-flop synchroniser; resets to the released level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM: a level change is accepted only after a stable run
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_REL;
            r_cnt   <= '0;
            r_evt   <= 1'b0;
        end else begin
            r_evt <= 1'b0;
            unique case (r_state)
                ST_REL: begin
                    if (w_s) begin
                        r_state <= ST_CHK_P;
                        r_cnt   <= ONE;
                    end
                end
                ST_CHK_P: begin
                    if (!w_s) begin
                        r_state <= ST_REL;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state <= ST_PRS;
                        r_cnt   <= '0;
                        r_evt   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                ST_PRS: begin
                    if (!w_s) begin
                        r_state <= ST_CHK_R;
                        r_cnt   <= ONE;
                    end
                end
                ST_CHK_R: begin
                    if (w_s) begin
                        r_state <= ST_PRS;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state <= ST_REL;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                default: begin
                    r_state <= ST_REL;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_btn_level = (r_state == ST_PRS) | (r_state == ST_CHK_R);
    assign o_press_evt = r_evt;

endmodule

// File: rtl/button_hit_conditioner.sv
// Turns the raw rhythm button into one held hit per press.
// A hit stays pending until the next beat tick consumes it.
module button_hit_conditioner
    import button_hit_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int CNT_W           = DEBOUNCE_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       tick,
    input  logic       enable,
    output logic       hit_n,
    output logic       btn_level,
    output logic [7:0] press_count,
    output logic       overrun
);

    logic       w_press_evt;
    logic       r_pending;
    logic [7:0] r_count;
    logic       r_overrun;

    button_hit_conditioner_debounce_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_btn_raw  (btn_raw),
        .o_btn_level(btn_level),
        .o_press_evt(w_press_evt)
    );

    // Pending hit latch; a press beats a coincident tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
            r_count   <= 8'd0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (!enable) begin
                r_pending <= 1'b0;
            end else if (w_press_evt) begin
                r_pending <= 1'b1;
                r_count   <= r_count + 8'd1;
                r_overrun <= r_pending & ~tick;
            end else if (tick) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign hit_n       = ~r_pending;
    assign press_count = r_count;
    assign overrun     = r_overrun;

endmodule
